// File: rtl/lbm_pkg.sv
// Shared types for the lattice-Boltzmann step sequencer: phase encoding,
// write-enable bundle and the per-phase enable decode.
package lbm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    MOMENT  = 3'd2,
    EQUIL   = 3'd3,
    COLLIDE = 3'd4,
    STREAM  = 3'd5,
    DONE    = 3'd6
  } phase_t;

  localparam int unsigned Q9 = 9;
  localparam int unsigned Q5 = 5;

  typedef struct packed {
    logic p;
    logic ux;
    logic uy;
    logic fin;
    logic fout;
    logic feq;
  } we_vec_t;

  // Moments are written once per node, on the issue carrying the last direction.
  function automatic we_vec_t we_decode(input phase_t ph, input logic last_dir);
    we_vec_t we;
    we = '0;
    case (ph)
      INIT: begin
        we.fin = 1'b1;
        we.p   = last_dir;
        we.ux  = last_dir;
        we.uy  = last_dir;
      end
      MOMENT: begin
        we.p  = last_dir;
        we.ux = last_dir;
        we.uy = last_dir;
      end
      EQUIL:   we.feq  = 1'b1;
      COLLIDE: we.fout = 1'b1;
      STREAM:  we.fin  = 1'b1;
      default: we = '0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/lbm_wr_delay.sv
// LAT-stage delay line aligning read-issue context with datapath write-back.
// Holds on stall, clears asynchronously on reset.
module lbm_wr_delay
  import lbm_pkg::*;
#(
  parameter int unsigned LAT    = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DIR_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall,
  input  logic              in_valid,
  input  phase_t            in_phase,
  input  logic [ADDR_W-1:0] in_node,
  input  logic [DIR_W-1:0]  in_dir,
  input  logic              in_last,
  output logic              out_valid,
  output phase_t            out_phase,
  output logic [ADDR_W-1:0] out_node,
  output logic [DIR_W-1:0]  out_dir,
  output logic              out_last
);

  typedef struct packed {
    logic              valid;
    phase_t            phase;
    logic [ADDR_W-1:0] node;
    logic [DIR_W-1:0]  dir;
    logic              last;
  } stage_t;

  stage_t pipe [LAT];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= '{valid: in_valid, phase: in_phase, node: in_node,
                   dir: in_dir, last: in_last};
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_valid = pipe[LAT-1].valid;
  assign out_phase = pipe[LAT-1].phase;
  assign out_node  = pipe[LAT-1].node;
  assign out_dir   = pipe[LAT-1].dir;
  assign out_last  = pipe[LAT-1].last;

endmodule

// File: rtl/lbm_step_sequencer.sv
// Lattice-Boltzmann time-step sequencer: INIT once, then MOMENT/EQUIL/
// COLLIDE/STREAM per iteration, with start/done handshake and stall.
module lbm_step_sequencer
  import lbm_pkg::*;
#(
  parameter int unsigned NX     = 4,
  parameter int unsigned NY     = 4,
  parameter int unsigned Q      = Q9,
  parameter int unsigned LAT    = 3,
  parameter int unsigned ITER_W = 16,
  localparam int unsigned N      = NX * NY,
  localparam int unsigned ADDR_W = $clog2(N),
  localparam int unsigned DIR_W  = $clog2(Q)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic [ITER_W-1:0] iter_count,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_node,
  output logic [DIR_W-1:0]  rd_dir,
  output logic [ADDR_W-1:0] wr_node,
  output logic [DIR_W-1:0]  wr_dir,
  output logic              WE_p_mem,
  output logic              WE_ux_mem,
  output logic              WE_uy_mem,
  output logic              WE_fin_mem,
  output logic              WE_fout_mem,
  output logic              WE_feq_mem,
  output logic              select_p,
  output logic              select_ux,
  output logic              select_uy,
  output logic              select_fin
);

  localparam int unsigned DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;

  phase_t              state_q, state_d;
  logic [ADDR_W-1:0]   node_q, node_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                draining_q, draining_d;
  logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
  logic [ITER_W-1:0]   num_q, num_d;
  logic                sweep, stall_eff, last_dir, last_issue;

  logic                d_valid, d_last;
  phase_t              d_phase;
  we_vec_t             we;

  assign last_dir   = (dir_q == DIR_W'(Q - 1));
  assign last_issue = last_dir && (node_q == ADDR_W'(N - 1));
  assign iter_inc   = iter_q + ITER_W'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      node_q     <= '0;
      dir_q      <= '0;
      drain_q    <= '0;
      draining_q <= 1'b0;
      iter_q     <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      dir_q      <= dir_d;
      drain_q    <= drain_d;
      draining_q <= draining_d;
      iter_q     <= iter_d;
      num_q      <= num_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    dir_d      = dir_q;
    drain_d    = drain_q;
    draining_d = draining_q;
    iter_d     = iter_q;
    num_d      = num_q;
    sweep      = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_iter;
          iter_d  = '0;
          state_d = INIT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        sweep = 1'b1;
        if (!stall) begin
          if (!draining_q) begin
            if (last_issue) begin
              draining_d = 1'b1;
              drain_d    = '0;
            end else if (last_dir) begin
              dir_d  = '0;
              node_d = node_q + ADDR_W'(1);
            end else begin
              dir_d = dir_q + DIR_W'(1);
            end
          end else if (drain_q == DRAIN_W'(LAT - 1)) begin
            // Drain complete: all writes of this phase have landed.
            draining_d = 1'b0;
            drain_d    = '0;
            node_d     = '0;
            dir_d      = '0;
            case (state_q)
              INIT:    state_d = (num_q == '0) ? DONE : MOMENT;
              MOMENT:  state_d = EQUIL;
              EQUIL:   state_d = COLLIDE;
              COLLIDE: state_d = STREAM;
              STREAM: begin
                iter_d  = iter_inc;
                state_d = (iter_inc == num_q) ? DONE : MOMENT;
              end
              default: state_d = IDLE;
            endcase
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end
    endcase
  end

  assign stall_eff = stall && sweep;
  assign rd_valid  = sweep && !draining_q && !stall;
  assign rd_node   = node_q;
  assign rd_dir    = dir_q;
  assign busy      = (state_q != IDLE);
  assign phase     = state_q;
  assign iter_count = iter_q;

  lbm_wr_delay #(
    .LAT    (LAT),
    .ADDR_W (ADDR_W),
    .DIR_W  (DIR_W)
  ) u_wr_delay (
    .Clk       (Clk),
    .Reset     (Reset),
    .stall     (stall_eff),
    .in_valid  (rd_valid),
    .in_phase  (state_q),
    .in_node   (node_q),
    .in_dir    (dir_q),
    .in_last   (last_dir),
    .out_valid (d_valid),
    .out_phase (d_phase),
    .out_node  (wr_node),
    .out_dir   (wr_dir),
    .out_last  (d_last)
  );

  assign we = (d_valid && !stall_eff) ? we_decode(d_phase, d_last) : '0;

  assign WE_p_mem    = we.p;
  assign WE_ux_mem   = we.ux;
  assign WE_uy_mem   = we.uy;
  assign WE_fin_mem  = we.fin;
  assign WE_fout_mem = we.fout;
  assign WE_feq_mem  = we.feq;

  assign select_p   = (state_q == INIT);
  assign select_ux  = (state_q == INIT);
  assign select_uy  = (state_q == INIT);
  assign select_fin = (state_q == INIT);

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Self-checking bench for lbm_step_sequencer (NX=2, NY=2, Q=9, LAT=2).
module tb_lbm_step_sequencer;

  localparam int NX = 2, NY = 2, Q = 9, LAT = 2, ITER_W = 16;
  localparam int N = NX * NY;
  localparam int NQ = N * Q;
  localparam int PH = NQ + LAT;
  localparam int BUDGET = 5000;

  logic              Clk, Reset, start, stall;
  logic [ITER_W-1:0] num_iter;
  logic              busy, done, rd_valid;
  logic [2:0]        phase;
  logic [ITER_W-1:0] iter_count;
  logic [1:0]        rd_node, wr_node;
  logic [3:0]        rd_dir, wr_dir;
  logic WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem;
  logic select_p, select_ux, select_uy, select_fin;

  lbm_step_sequencer #(
    .NX(NX), .NY(NY), .Q(Q), .LAT(LAT), .ITER_W(ITER_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .num_iter(num_iter), .stall(stall),
    .busy(busy), .done(done), .phase(phase), .iter_count(iter_count),
    .rd_valid(rd_valid), .rd_node(rd_node), .rd_dir(rd_dir),
    .wr_node(wr_node), .wr_dir(wr_dir),
    .WE_p_mem(WE_p_mem), .WE_ux_mem(WE_ux_mem), .WE_uy_mem(WE_uy_mem),
    .WE_fin_mem(WE_fin_mem), .WE_fout_mem(WE_fout_mem), .WE_feq_mem(WE_feq_mem),
    .select_p(select_p), .select_ux(select_ux), .select_uy(select_uy),
    .select_fin(select_fin)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int node; int dir; int ph; int t; } rd_t;
  rd_t rq[$];

  int r_cycles, r_fin, r_p, r_ux, r_uy, r_feq, r_fout, r_stalls, r_reads, r_found;
  int addr_err, wr_err, stall_err;
  int last_fout_cyc, last_fout_node, last_fout_dir, last_coll_cyc;

  // Phase sequence from the iteration rule: INIT, then MOMENT..STREAM repeated.
  function automatic int model_phase(input int p);
    return (p == 0) ? 1 : 2 + ((p - 1) % 4);
  endfunction

  // mode 0: plain / random stall, 1: 5-cycle stall at EQUIL (1,4), 2: start poke in MOMENT
  task automatic run(input int n, input int pct, input int mode);
    int pidx, idx, ucnt, eq_left, poked;
    logic [5:0] act, expv;
    rd_t e;
    r_cycles = 0; r_fin = 0; r_p = 0; r_ux = 0; r_uy = 0; r_feq = 0; r_fout = 0;
    r_stalls = 0; r_reads = 0; r_found = 0; addr_err = 0; wr_err = 0; stall_err = 0;
    last_fout_cyc = -1; last_fout_node = -1; last_fout_dir = -1; last_coll_cyc = -2;
    rq.delete();
    pidx = 0; idx = 0; ucnt = 0; eq_left = 5; poked = 0;
    @(negedge Clk);
    start = 1'b1; num_iter = ITER_W'(n); stall = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (c > 0) @(negedge Clk);
      start = 1'b0;
      stall = 1'b0;
      if (mode == 1 && eq_left > 0 && model_phase(pidx) == 3 && idx == 13) begin
        stall = 1'b1; eq_left--;
      end else if (pct > 0) begin
        stall = ($urandom_range(99) < pct);
      end
      if (mode == 2 && poked == 0 && pidx == 1 && idx == 5) begin
        start = 1'b1; num_iter = ITER_W'(3); poked = 1;
      end
      #1;
      if (c == 0) check("busy_rise", busy, 1);
      if (done) begin
        r_found = 1;
        check("done_busy", busy, 1);
        break;
      end
      act = {WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem};
      r_p += WE_p_mem; r_ux += WE_ux_mem; r_uy += WE_uy_mem;
      r_fin += WE_fin_mem; r_fout += WE_fout_mem; r_feq += WE_feq_mem;
      if (phase == 3'd4) last_coll_cyc = r_cycles;
      if (stall) begin
        r_stalls++;
        if (rd_valid || act != 6'd0) stall_err++;
        if (mode == 1 && (rd_node != 2'd1 || rd_dir != 4'd4)) stall_err++;
      end else begin
        ucnt++;
        if (rd_valid) begin
          r_reads++;
          if (pidx > 4 * n || phase != 3'(model_phase(pidx)) ||
              rd_node != 2'(idx / Q) || rd_dir != 4'(idx % Q) ||
              select_fin != (model_phase(pidx) == 1) || select_p != select_fin ||
              select_ux != select_fin || select_uy != select_fin)
            addr_err++;
          rq.push_back('{node: idx / Q, dir: idx % Q, ph: model_phase(pidx), t: ucnt});
          idx++;
          if (idx == NQ) begin idx = 0; pidx++; end
        end
        expv = 6'd0;
        if (rq.size() > 0 && rq[0].t + LAT == ucnt) begin
          e = rq.pop_front();
          expv[2] = (e.ph == 1 || e.ph == 5);
          expv[5] = (e.ph == 1 || e.ph == 2) && (e.dir == Q - 1);
          expv[4] = expv[5];
          expv[3] = expv[5];
          expv[1] = (e.ph == 4);
          expv[0] = (e.ph == 3);
          if (wr_node != 2'(e.node) || wr_dir != 4'(e.dir)) wr_err++;
        end
        if (act != expv) wr_err++;
        if (WE_fout_mem) begin
          last_fout_cyc = r_cycles; last_fout_node = wr_node; last_fout_dir = wr_dir;
        end
      end
      r_cycles++;
    end
    stall = 1'b0; start = 1'b0;
    check("done_seen", r_found, 1);
    check("read_count", r_reads, NQ * (1 + 4 * n));
    check("pending_writes", rq.size(), 0);
    check("addr_seq_err", addr_err, 0);
    check("write_err", wr_err, 0);
    check("stall_err", stall_err, 0);
    @(negedge Clk); #1;
    check("idle_after_done", {busy, done, phase}, 0);
    check("iter_hold", iter_count, n);
  endtask

  typedef struct { int n; int cycles; int fin; int p; int feq; int fout; } vec_t;
  vec_t tbl[3];

  initial begin
    int n;
    Reset = 1'b0; start = 1'b0; stall = 1'b0; num_iter = '0;
    repeat (3) @(negedge Clk);
    #1;
    check("reset_state", {busy, done, phase, iter_count, rd_valid, rd_node, rd_dir,
                          wr_node, wr_dir, WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem,
                          WE_fout_mem, WE_feq_mem, select_p, select_ux, select_uy,
                          select_fin}, 0);
    @(negedge Clk);
    Reset = 1'b1;

    tbl[0] = '{n: 0, cycles: 38,  fin: 36,  p: 4,  feq: 0,  fout: 0};
    tbl[1] = '{n: 1, cycles: 190, fin: 72,  p: 8,  feq: 36, fout: 36};
    tbl[2] = '{n: 2, cycles: 342, fin: 108, p: 12, feq: 72, fout: 72};
    for (int i = 0; i < 3; i++) begin
      run(tbl[i].n, 0, 0);
      check("tbl_cycles", r_cycles, tbl[i].cycles);
      check("tbl_we_fin", r_fin, tbl[i].fin);
      check("tbl_we_p", r_p, tbl[i].p);
      check("tbl_we_ux", r_ux, tbl[i].p);
      check("tbl_we_uy", r_uy, tbl[i].p);
      check("tbl_we_feq", r_feq, tbl[i].feq);
      check("tbl_we_fout", r_fout, tbl[i].fout);
      if (tbl[i].n != 0) begin
        check("last_fout_node", last_fout_node, 3);
        check("last_fout_dir", last_fout_dir, 8);
        check("last_fout_in_final_drain", last_fout_cyc, last_coll_cyc);
      end
    end

    // Stall for 5 cycles in EQUIL just before issue (1,4).
    run(1, 0, 1);
    check("eq_stall_cycles", r_cycles, 190 + 5);
    check("eq_stall_count", r_stalls, 5);
    check("eq_stall_feq", r_feq, 36);

    // start pulse during MOMENT must be ignored.
    run(1, 0, 2);
    check("busy_start_cycles", r_cycles, 190);
    check("busy_start_fout", r_fout, 36);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(3);
      run(n, $urandom_range(5, 30), 0);
      check("rnd_cycles", r_cycles, PH * (1 + 4 * n) + r_stalls);
      check("rnd_we_fin", r_fin, NQ * (1 + n));
      check("rnd_we_p", r_p, N * (1 + n));
      check("rnd_we_feq", r_feq, NQ * n);
      check("rnd_we_fout", r_fout, NQ * n);
    end

    // Asynchronous reset in STREAM, then a fresh two-iteration run.
    @(negedge Clk);
    start = 1'b1; num_iter = ITER_W'(1);
    @(negedge Clk);
    start = 1'b0;
    for (int c = 0; c < 400 && phase != 3'd5; c++) @(negedge Clk);
    check("reached_stream", phase, 5);
    #3 Reset = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, phase, iter_count, rd_valid, rd_node, rd_dir,
                                  wr_node, wr_dir, WE_p_mem, WE_ux_mem, WE_uy_mem,
                                  WE_fin_mem, WE_fout_mem, WE_feq_mem, select_p,
                                  select_ux, select_uy, select_fin}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    run(2, 0, 0);
    check("post_reset_cycles", r_cycles, 342);
    check("post_reset_fin", r_fin, 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbm_step_sequencer.md
Name: lbm_step_sequencer

Overview:
- Parametrised successor to the LBM moment controller.
- Sequences complete lattice-Boltzmann time steps over an NX x NY lattice with Q velocity directions. Each step runs MOMENT, EQUIL, COLLIDE and STREAM after a one-time INIT.
- Per phase it drives node/direction read addresses to the datapath and memory write enables, delayed by the datapath pipeline latency. It adds a start/done handshake, a programmable iteration count and a stall input.

Parameters:
- NX, 4, lattice width in nodes.
- NY, 4, lattice height in nodes.
- Q, 9, directions per node; legal values 5 or 9.
- LAT, 3, datapath read-to-write latency in cycles; must be >= 1.
- ITER_W, 16, width of the iteration count.
- Derived localparams:
  - N = NX*NY
  - ADDR_W = $clog2(N)
  - DIR_W = $clog2(Q)

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, asynchronous active-low reset.
- start, in, 1, begin a run; sampled only in IDLE.
- num_iter, in, ITER_W, time steps to run; latched on start.
- stall, in, 1, datapath backpressure; freezes the sequencer.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at run end.
- phase, out, 3, current phase_t.
- iter_count, out, ITER_W, completed time steps.
- rd_valid, out, 1, read issue valid.
- rd_node, out, ADDR_W, read node address.
- rd_dir, out, DIR_W, read direction.
- wr_node, out, ADDR_W, write node address (rd_node delayed by LAT).
- wr_dir, out, DIR_W, write direction (rd_dir delayed by LAT).
- WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem, out, 1 each, memory write enables.
- select_p, select_ux, select_uy, select_fin, out, 1 each, 1 = write-data source is the init constant, 0 = datapath.

Behaviour:
- Reset asserted (low), at any time including mid-run:
  - State goes to IDLE, counters clear, delay pipeline clears.
  - All outputs are 0.
- States: IDLE, INIT, MOMENT, EQUIL, COLLIDE, STREAM, DONE.
- IDLE:
  - start=1 latches num_iter and clears iter_count; next state is INIT.
  - start is ignored in every other state.
- Sweep (every phase INIT..STREAM):
  - rd_valid=1 for exactly N*Q un-stalled cycles.
  - Addressing: rd_dir is the inner loop 0..Q-1 and rd_node the outer loop 0..N-1; both restart at 0 on phase entry.
  - After the last issue, a drain of LAT cycles with rd_valid=0.
  - The next state is entered on the cycle after the drain ends, so a phase lasts N*Q+LAT cycles with no stall.
- Write enables:
  - Asserted on cycles where the LAT-delayed valid is 1.
  - Qualified by the delayed phase and delayed last-direction flag, so writes from the final issues land during the drain.
  - INIT: WE_fin every entry; WE_p/ux/uy only when delayed dir==Q-1; select_p/ux/uy/fin=1 throughout INIT.
  - MOMENT: WE_p/ux/uy when delayed dir==Q-1.
  - EQUIL: WE_feq every entry.
  - COLLIDE: WE_fout every entry.
  - STREAM: WE_fin every entry. The neighbour address is computed by the datapath from wr_node/wr_dir.
- Iteration control:
  - INIT goes to MOMENT, or to DONE if num_iter==0.
  - STREAM completion increments iter_count, then goes to DONE if the new value == num_iter, else to MOMENT.
- DONE: lasts one cycle with done=1 and busy=1, then returns to IDLE. iter_count holds until the next start.
- stall=1:
  - State, counters, drain counter and delay pipeline all hold.
  - rd_valid and all WE_* are forced to 0 that cycle.
  - stall in IDLE or DONE has no effect.
- Counters wrap only via phase restart; no free-running wrap.
- num_iter = 2^ITER_W-1 is legal.

Decomposition:
- Package lbm_pkg:
  - phase_t enum (IDLE=0, INIT, MOMENT, EQUIL, COLLIDE, STREAM, DONE).
  - Q9/Q5 constants.
  - A we_vec_t struct of the six enables.
- Sub-module lbm_wr_delay: a LAT-stage shift register carrying {valid, phase, node, dir, last_dir}, with a stall hold and async clear.
- Top module holds the FSM, the node/dir/drain/iteration counters and the enable decode.

Test Plan (NX=2, NY=2, Q=9, LAT=2, so 38 cycles per phase):
- Basic run: num_iter=1, start pulse. busy rises the cycle after start; done pulses exactly 190 cycles later. Expected counts:
  - WE_fin: 72 pulses (36 INIT + 36 STREAM).
  - WE_p, WE_ux, WE_uy: 8 pulses each.
  - WE_feq: 36 pulses; WE_fout: 36 pulses.
  - iter_count=1.
- Zero iterations: num_iter=0. INIT only; done after 38 cycles; WE_feq and WE_fout never assert.
- Latency alignment: in COLLIDE, each WE_fout pulse has (wr_node,wr_dir) equal to (rd_node,rd_dir) from 2 cycles earlier. The last write, (3,8), occurs in the final drain cycle.
- Stall: stall=1 for 5 cycles mid-EQUIL with rd_node=1, rd_dir=4. Outputs hold, rd_valid=0, WE_feq=0; the sequence resumes at (1,4) and total run time grows by exactly 5.
- Reset mid-run: assert Reset low during STREAM. Outputs go to 0 asynchronously. After release, a start with num_iter=2 completes in 38+2*4*38=342 cycles.
- start while busy: a pulse during MOMENT is ignored; num_iter is unchanged and no restart occurs.
